// File: rtl/descrambler_ctrl.sv
// descrambler_ctrl: 64b/66b block aligner and sequencer for one lane.
// Hunts sync headers, locks, and gates the descrambler enable/re-seed.
module descrambler_ctrl #(
    parameter int BLOCK_LEN  = 66,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_LIMIT  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ctrl_en,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       rescramble_req,
    output logic       desc_bit,
    output logic       desc_enable,
    output logic       desc_scr_rst,
    output logic       block_lock,
    output logic       block_start,
    output logic [1:0] sync_hdr,
    output logic       hdr_err
);

    localparam int PW = $clog2(BLOCK_LEN);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(ERR_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        VERIFY = 2'd2,
        LOCKED = 2'd3
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [PW-1:0] pos;
    logic          h0;
    logic [GW-1:0] good_cnt;
    logic [BW-1:0] bad_cnt;
    logic          scr_pend;

    logic          accept;
    logic          at_h0;
    logic          at_h1;
    logic          eval;
    logic          hdr_ok;
    logic          pend_eff;
    logic [GW-1:0] good_inc;
    logic [BW-1:0] bad_inc;
    logic          lock_gain;
    logic          lock_loss;
    logic          slip;

    logic          desc_bit_n;
    logic          desc_enable_n;
    logic          desc_scr_rst_n;
    logic          block_lock_n;
    logic          block_start_n;
    logic [1:0]    sync_hdr_n;
    logic          hdr_err_n;

    // Per-bit qualifiers shared by the FSM, datapath and outputs
    always_comb begin
        accept    = bit_valid && ctrl_en && (state != IDLE);
        at_h0     = (pos == PW'(0));
        at_h1     = (pos == PW'(1));
        eval      = accept && at_h1;
        hdr_ok    = h0 ^ bit_in;
        pend_eff  = scr_pend | rescramble_req;
        good_inc  = good_cnt + GW'(1);
        bad_inc   = bad_cnt + BW'(1);
        lock_gain = eval && (state == VERIFY) && hdr_ok
                    && (good_inc >= GW'(LOCK_COUNT));
        lock_loss = eval && (state == LOCKED) && !hdr_ok
                    && (bad_inc >= BW'(ERR_LIMIT));
        slip      = eval && !hdr_ok
                    && ((state == HUNT) || (state == VERIFY));
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decision from header evaluation
    always_comb begin
        state_n = state;
        if (!ctrl_en) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = HUNT;
                end
                HUNT: begin
                    if (eval && hdr_ok) begin
                        state_n = VERIFY;
                    end
                end
                VERIFY: begin
                    if (lock_gain) begin
                        state_n = LOCKED;
                    end else if (slip) begin
                        state_n = HUNT;
                    end
                end
                LOCKED: begin
                    if (lock_loss) begin
                        state_n = HUNT;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Block position tracking, including the one-bit slip
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos <= '0;
            h0  <= 1'b0;
        end else if (!ctrl_en || (state == IDLE)) begin
            pos <= '0;
            h0  <= 1'b0;
        end else if (accept) begin
            if (at_h0) begin
                h0  <= bit_in;
                pos <= PW'(1);
            end else if (at_h1) begin
                if (slip) begin
                    h0  <= bit_in;
                    pos <= PW'(1);
                end else if (lock_loss) begin
                    pos <= '0;
                end else begin
                    pos <= PW'(2);
                end
            end else if (pos == PW'(BLOCK_LEN - 1)) begin
                pos <= '0;
            end else begin
                pos <= pos + PW'(1);
            end
        end
    end

    // Good/bad header run counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else if (!ctrl_en || (state == IDLE)) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else if (eval) begin
            unique case (state)
                HUNT: begin
                    good_cnt <= hdr_ok ? GW'(1) : '0;
                    bad_cnt  <= '0;
                end
                VERIFY: begin
                    if (hdr_ok && !lock_gain) begin
                        good_cnt <= good_inc;
                    end else begin
                        good_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (hdr_ok || lock_loss) begin
                        bad_cnt <= '0;
                    end else begin
                        bad_cnt <= bad_inc;
                    end
                end
                default: begin
                    good_cnt <= '0;
                    bad_cnt  <= '0;
                end
            endcase
        end
    end

    // Pending re-seed: armed by requests in LOCKED, consumed at h1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scr_pend <= 1'b0;
        end else if (!ctrl_en || (state != LOCKED) || lock_loss) begin
            scr_pend <= 1'b0;
        end else if (eval) begin
            scr_pend <= 1'b0;
        end else if (rescramble_req) begin
            scr_pend <= 1'b1;
        end
    end

    // Next output values for the accepted bit
    always_comb begin
        desc_bit_n     = accept ? bit_in : desc_bit;
        desc_enable_n  = accept && (state == LOCKED) && (pos >= PW'(2));
        desc_scr_rst_n = lock_gain
                         || (eval && (state == LOCKED)
                             && pend_eff && !lock_loss);
        block_lock_n   = (state_n == LOCKED);
        block_start_n  = accept && (state == LOCKED) && at_h0;
        hdr_err_n      = eval && !hdr_ok
                         && ((state == VERIFY) || (state == LOCKED));
        sync_hdr_n     = sync_hdr;
        if (eval && (state == LOCKED) && hdr_ok) begin
            sync_hdr_n = {h0, bit_in};
        end
        if (!ctrl_en) begin
            desc_bit_n     = 1'b0;
            desc_enable_n  = 1'b0;
            desc_scr_rst_n = 1'b0;
            block_lock_n   = 1'b0;
            block_start_n  = 1'b0;
            hdr_err_n      = 1'b0;
            sync_hdr_n     = 2'b00;
        end
    end

    // Registered outputs, one cycle behind the accepted bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            desc_bit     <= 1'b0;
            desc_enable  <= 1'b0;
            desc_scr_rst <= 1'b0;
            block_lock   <= 1'b0;
            block_start  <= 1'b0;
            sync_hdr     <= 2'b00;
            hdr_err      <= 1'b0;
        end else begin
            desc_bit     <= desc_bit_n;
            desc_enable  <= desc_enable_n;
            desc_scr_rst <= desc_scr_rst_n;
            block_lock   <= block_lock_n;
            block_start  <= block_start_n;
            sync_hdr     <= sync_hdr_n;
            hdr_err      <= hdr_err_n;
        end
    end

endmodule

// File: tb/tb_descrambler_ctrl.sv
// tb_descrambler_ctrl: directed, table-driven checks of block alignment,
// lock/unlock, re-seed and gating behaviour of descrambler_ctrl.
module tb_descrambler_ctrl;

    logic       clk;
    logic       rst;
    logic       ctrl_en;
    logic       bit_in;
    logic       bit_valid;
    logic       rescramble_req;
    logic       desc_bit;
    logic       desc_enable;
    logic       desc_scr_rst;
    logic       block_lock;
    logic       block_start;
    logic [1:0] sync_hdr;
    logic       hdr_err;

    int total;
    int bad;
    int cur;

    descrambler_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .ctrl_en        (ctrl_en),
        .bit_in         (bit_in),
        .bit_valid      (bit_valid),
        .rescramble_req (rescramble_req),
        .desc_bit       (desc_bit),
        .desc_enable    (desc_enable),
        .desc_scr_rst   (desc_scr_rst),
        .block_lock     (block_lock),
        .block_start    (block_start),
        .sync_hdr       (sync_hdr),
        .hdr_err        (hdr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   first;
        int   last;
        logic en;
        logic sr;
        logic lk;
        logic st;
    } seg_t;

    seg_t tbl [10];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s idx=%0d got=%0d want=%0d", nm, cur, act, exp);
        end
    endtask

    task automatic step(input logic b, input logic v, input logic req);
        bit_in         = b;
        bit_valid      = v;
        rescramble_req = req;
        @(posedge clk);
        #1;
        rescramble_req = 1'b0;
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_bit"}, desc_bit, 0);
        chk({nm, "_en"}, desc_enable, 0);
        chk({nm, "_sr"}, desc_scr_rst, 0);
        chk({nm, "_lock"}, block_lock, 0);
        chk({nm, "_start"}, block_start, 0);
        chk({nm, "_hdr"}, sync_hdr, 0);
        chk({nm, "_err"}, hdr_err, 0);
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        ctrl_en        = 1'b0;
        bit_valid      = 1'b0;
        bit_in         = 1'b0;
        rescramble_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst     = 1'b1;
        ctrl_en = 1'b1;
        step(1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic pl(input int i);
        int t;
        t = (i * 13) >> 2;
        return t[0];
    endfunction

    // Aligned stream: header 01 at every multiple of 66
    function automatic logic gen1(input int i);
        int p;
        p = i % 66;
        if (p == 0) return 1'b0;
        if (p == 1) return 1'b1;
        return pl(i);
    endfunction

    // Offset stream: 69 junk ones, then header 10 every 66 bits
    function automatic logic gen2(input int i);
        int p;
        if (i < 69) return 1'b1;
        p = (i - 69) % 66;
        if (p == 0) return 1'b1;
        if (p == 1) return 1'b0;
        return pl(i);
    endfunction

    // Relock from HUNT with the aligned stream; returns at bit 199
    task automatic relock(input string nm);
        for (int i = 0; i < 200; i++) begin
            cur = i;
            step(gen1(i), 1'b1, 1'b0);
            if (i == 133) chk({nm, "_lock3"}, block_lock, 0);
            if (i == 199) begin
                chk({nm, "_lock4"}, block_lock, 1);
                chk({nm, "_sr4"}, desc_scr_rst, 1);
            end
        end
    endtask

    initial begin
        int   errs;
        int   srs;
        int   p;
        logic b;
        bit   bad_hdr [6];

        total = 0;
        bad   = 0;
        cur   = 0;

        tbl[0] = '{0,   198, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{199, 199, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{200, 263, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{264, 264, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{265, 265, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{266, 329, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{330, 330, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{331, 331, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{332, 370, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[9] = '{371, 370, 1'b0, 1'b0, 1'b0, 1'b0};

        // Aligned stream, table-driven profile
        do_reset();
        for (int s = 0; s < 10; s++) begin
            for (int i = tbl[s].first; i <= tbl[s].last; i++) begin
                cur = i;
                b = gen1(i);
                step(b, 1'b1, 1'b0);
                chk("t1_bit", desc_bit, b);
                chk("t1_en", desc_enable, tbl[s].en);
                chk("t1_sr", desc_scr_rst, tbl[s].sr);
                chk("t1_lock", block_lock, tbl[s].lk);
                chk("t1_start", block_start, tbl[s].st);
            end
        end

        // Async reset at pos 40 while locked, then relock
        #2 rst = 1'b0;
        #1 check_zero("arst");
        #2 rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        relock("arst");

        // ctrl_en drop at pos 40 while locked, then relock
        for (int i = 200; i < 238; i++) begin
            cur = i;
            step(gen1(i), 1'b1, 1'b0);
        end
        chk("cen_pre_lock", block_lock, 1);
        cur = 238;
        ctrl_en = 1'b0;
        step(gen1(238), 1'b1, 1'b0);
        check_zero("cen");
        ctrl_en = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        relock("cen");

        // Offset stream with junk prefix: hunt, verify, lock
        do_reset();
        for (int i = 0; i <= 494; i++) begin
            cur = i;
            b = gen2(i);
            p = (i >= 69) ? (i - 69) % 66 : -1;
            step(b, 1'b1, 1'b0);
            chk("t2_err", hdr_err, 0);
            chk("t2_lock", block_lock, (i >= 268) ? 1 : 0);
            chk("t2_sr", desc_scr_rst, (i == 268) ? 1 : 0);
            chk("t2_start", block_start, (i > 268 && p == 0) ? 1 : 0);
        end
        chk("t2_sync_hdr", sync_hdr, 2);

        // Two rescramble requests in one block give one re-seed
        srs = 0;
        for (int i = 495; i <= 600; i++) begin
            cur = i;
            p = (i - 69) % 66;
            step(gen2(i), 1'b1, (i == 495 || i == 505));
            if (desc_scr_rst) srs++;
            chk("t4_sr", desc_scr_rst, (i == 532) ? 1 : 0);
            chk("t4_en", desc_enable, (p >= 2) ? 1 : 0);
        end
        chk("t4_sr_count", srs, 1);

        // bit_valid toggling while locked
        for (int i = 601; i <= 728; i++) begin
            cur = i;
            b = gen2(i);
            p = (i - 69) % 66;
            step(b, 1'b1, 1'b0);
            chk("t5_bit", desc_bit, b);
            chk("t5_en", desc_enable, (p >= 2) ? 1 : 0);
            chk("t5_start", block_start, (p == 0) ? 1 : 0);
            step(~b, 1'b0, 1'b0);
            chk("t5_hold", desc_bit, b);
            chk("t5_gap_en", desc_enable, 0);
            chk("t5_gap_start", block_start, 0);
            chk("t5_gap_sr", desc_scr_rst, 0);
        end

        // Header errors: bad, bad, good, bad, bad, bad
        bad_hdr = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        errs = 0;
        for (int j = 0; j < 6; j++) begin
            for (int q = 0; q < 66; q++) begin
                cur = 729 + 66 * j + q;
                if (q == 0) b = 1'b1;
                else if (q == 1) b = bad_hdr[j] ? 1'b1 : 1'b0;
                else b = pl(cur);
                step(b, 1'b1, 1'b0);
                if (hdr_err) errs++;
                if (q == 1) begin
                    chk("t3_err", hdr_err, bad_hdr[j]);
                    chk("t3_lock", block_lock, (j < 5) ? 1 : 0);
                end
                if (j == 5 && q >= 2) begin
                    chk("t3_en_after", desc_enable, 0);
                    chk("t3_lock_after", block_lock, 0);
                end
            end
        end
        chk("t3_err_count", errs, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
